strm_traffic_engine: RTL

// - Synthesizable multi-channel AXI4-Stream traffic generator/checker for user-logic bring-up and self-test.
// - Each of N_CHAN channels sends a programmed-length pattern stream and checks the returning stream against the same pattern.
// - Replaces simulation-only stream drivers so the same test runs in hardware.
// - Sits between the user CSR block (start/len/seed, status readback) and the host/card stream ports.

---
 rtl/strm_traffic_engine.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/strm_traffic_engine.sv
// Multi-channel AXI4-Stream pattern generator/checker for bring-up and self-test.
// Each channel sends a seeded counting pattern and checks the returning stream against it.
module strm_traffic_engine #(
  parameter int N_CHAN    = 2,
  parameter int DATA_BITS = 512,
  parameter int LEN_BITS  = 28,
  parameter int ERR_BITS  = 16
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [N_CHAN-1:0]               start,
  input  logic [N_CHAN*LEN_BITS-1:0]      len_bytes,
  input  logic [N_CHAN*32-1:0]            seed,
  output logic [N_CHAN-1:0]               send_tvalid,
  input  logic [N_CHAN-1:0]               send_tready,
  output logic [N_CHAN*DATA_BITS-1:0]     send_tdata,
  output logic [N_CHAN*DATA_BITS/8-1:0]   send_tkeep,
  output logic [N_CHAN-1:0]               send_tlast,
  input  logic [N_CHAN-1:0]               recv_tvalid,
  output logic [N_CHAN-1:0]               recv_tready,
  input  logic [N_CHAN*DATA_BITS-1:0]     recv_tdata,
  input  logic [N_CHAN*DATA_BITS/8-1:0]   recv_tkeep,
  input  logic [N_CHAN-1:0]               recv_tlast,
  output logic [N_CHAN-1:0]               busy,
  output logic [N_CHAN-1:0]               done,
  output logic [N_CHAN-1:0]               irq,
  output logic [N_CHAN*ERR_BITS-1:0]      err_cnt
);

  localparam int BB  = DATA_BITS / 8;
  localparam int WPB = DATA_BITS / 32;
  localparam int BSH = $clog2(BB);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic [DATA_BITS-1:0] pattern(input logic [31:0] sd,
                                                   input logic [LEN_BITS-1:0] beat);
    logic [31:0] base;
    base = sd + 32'(beat) * 32'(WPB);
    for (int w = 0; w < WPB; w++) pattern[w*32 +: 32] = base + 32'(w);
  endfunction

  function automatic logic [BB-1:0] keep_of(input logic [BSH-1:0] rem, input logic last);
    if (last && rem != '0) keep_of = ~({BB{1'b1}} << rem);
    else                   keep_of = {BB{1'b1}};
  endfunction

  // Held low through reset so recv_tready stays 0 until the first clock after release.
  logic live;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) live <= 1'b0;
    else          live <= 1'b1;
  end

  for (genvar c = 0; c < N_CHAN; c++) begin : g_ch
    logic [1:0]           state;
    logic [LEN_BITS-1:0]  scnt, rcnt, scnt_n, rcnt_n, nb_r, nb_in, in_len;
    logic [BSH-1:0]       rem_r;
    logic [31:0]          seed_r;
    logic [ERR_BITS-1:0]  err;
    logic                 irq_r, accept, s_vld, s_hs, s_last, r_rdy, r_hs, r_last, mism;
    logic [BB-1:0]        r_keep;
    logic [DATA_BITS-1:0] r_data;

    assign in_len = len_bytes[c*LEN_BITS +: LEN_BITS];
    assign nb_in  = LEN_BITS'(({1'b0, in_len} + (LEN_BITS+1)'(BB - 1)) >> BSH);
    assign accept = start[c] && (state != S_RUN);

    assign s_vld  = (state == S_RUN) && (scnt != nb_r);
    assign s_hs   = s_vld && send_tready[c];
    assign s_last = (scnt == nb_r - LEN_BITS'(1));
    assign scnt_n = scnt + LEN_BITS'(s_hs);

    // Outside RUN every arriving beat is drained and counted as an error.
    assign r_rdy  = live && ((state != S_RUN) || (rcnt != nb_r));
    assign r_hs   = r_rdy && recv_tvalid[c];
    assign r_last = (rcnt == nb_r - LEN_BITS'(1));
    assign rcnt_n = rcnt + LEN_BITS'(r_hs);
    assign r_keep = keep_of(rem_r, r_last);
    assign r_data = pattern(seed_r, rcnt);

    always_comb begin
      mism = 1'b0;
      for (int b = 0; b < BB; b++)
        if (r_keep[b] && (recv_tdata[c*DATA_BITS + b*8 +: 8] != r_data[b*8 +: 8])) mism = 1'b1;
      if (recv_tkeep[c*BB +: BB] != r_keep) mism = 1'b1;
      if (recv_tlast[c] != r_last)          mism = 1'b1;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        state <= S_IDLE;
        scnt  <= '0;
        rcnt  <= '0;
        err   <= '0;
        irq_r <= 1'b0;
      end else begin
        irq_r <= 1'b0;
        if (accept) begin
          state <= (nb_in == '0) ? S_DONE : S_RUN;
          irq_r <= (nb_in == '0);
          scnt  <= '0;
          rcnt  <= '0;
          err   <= '0;
        end else begin
          if (state == S_RUN) begin
            scnt <= scnt_n;
            rcnt <= rcnt_n;
            if ((scnt_n == nb_r) && (rcnt_n == nb_r)) begin
              state <= S_DONE;
              irq_r <= 1'b1;
            end
          end
          if (r_hs && ((state != S_RUN) || mism) && (err != '1))
            err <= err + ERR_BITS'(1);
        end
      end
    end

    always_ff @(posedge aclk) begin
      if (accept) begin
        seed_r <= seed[c*32 +: 32];
        rem_r  <= in_len[BSH-1:0];
        nb_r   <= nb_in;
      end
    end

    assign send_tvalid[c]                  = s_vld;
    assign send_tdata[c*DATA_BITS +: DATA_BITS] = s_vld ? pattern(seed_r, scnt) : '0;
    assign send_tkeep[c*BB +: BB]          = s_vld ? keep_of(rem_r, s_last) : '0;
    assign send_tlast[c]                   = s_vld && s_last;
    assign recv_tready[c]                  = r_rdy;
    assign busy[c]                         = (state == S_RUN);
    assign done[c]                         = (state == S_DONE);
    assign irq[c]                          = irq_r;
    assign err_cnt[c*ERR_BITS +: ERR_BITS] = err;
  end

endmodule
